cluster_extract_seq: RTL and testbench
======================================

# cluster_extract_seq

Sequencer that extracts up to MXCLUSTERS clusters per event from a 192-pad valid-pattern vector by driving the shared priority encoder iteratively. Each pass it presents the remaining pattern and waits the encoder's pipeline latency. It then records the winning cluster and masks the pads that cluster covers before starting the next pass. It sits between the per-partition cluster finder and the cluster packer, and replaces one-encoder-per-cluster builds.

## Interface
- MXKEYS, 192, pads in the valid-pattern vector
- MXKEYBITS, 8, encoder address width
- MXCLUSTERS, 8, maximum clusters extracted per event (1..15)
- ENC_LAT, 2, encoder latency in clocks from enc_vpfs change to valid result (>=1)

- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle event strobe; qualifies vpfs_in/cnts_in/pass_in
- vpfs_in  in  MXKEYS  pad valid flags
- cnts_in  in  3*MXKEYS  per-pad cluster count (size-1)
- pass_in  in  3  event tag
- enc_vpfs  out  MXKEYS  remaining pattern driven to encoder (registered)
- enc_cnts  out  3*MXKEYS  counts driven to encoder (registered)
- enc_vpf  in  1  encoder found-flag
- enc_cnt  in  3  encoder winner count
- enc_adr  in  MXKEYBITS  encoder winner address
- busy  out  1  extraction in progress
- done  out  1  one-cycle pulse: clusters/pass_out valid
- clusters  out  12*MXCLUSTERS  slot i = {vpf, cnt[2:0], adr[7:0]} at bits [12i+11:12i]
- nclusters  out  4  number of valid slots
- pass_out  out  3  pass_in latched at start
- start_lost  out  1  one-cycle pulse: start arrived while busy

## Operation
- States: IDLE, RUN, FINISH.
- IDLE with start=1:
  - load enc_vpfs<=vpfs_in, enc_cnts<=cnts_in, pass_out<=pass_in.
  - Clear the iteration counter and wait counter; go to RUN.
- RUN:
  - The wait counter counts ENC_LAT clocks after each enc_vpfs load.
  - On the edge the count expires, store {enc_vpf, enc_cnt, enc_adr} into slot iter.
  - If enc_vpf=1, clear enc_vpfs bits adr..min(adr+cnt, MXKEYS-1) on the same edge, then reload the wait counter.
  - If enc_adr>=MXKEYS, nothing is masked.
  - If enc_vpf=0, the slot is written {0, 3'd0, 8'hFF}.
  - After slot MXCLUSTERS-1 is written, go to FINISH.
- FINISH: assert done for one cycle, update nclusters, return to IDLE.
  - nclusters is the count of slots with vpf=1, ranging 0..MXCLUSTERS.
- clusters and nclusters hold their values until the next FINISH.
- start while busy=1 is ignored and start_lost pulses the following cycle. The event in flight is unaffected.
- enc_cnts is constant for an event and only reloads on an accepted start.

## Timing
- Reset values:
  - busy=0, done=0, start_lost=0, nclusters=0, pass_out=0.
  - enc_vpfs=0, enc_cnts=0.
  - Every clusters slot is {0, 0, 8'hFF}.
  - State is IDLE.
- Accepted start sampled at edge t0; busy=1 from t0.
- Slot i is captured at edge t0+ENC_LAT*(i+1).
- done=1 in the cycle after edge t0+ENC_LAT*MXCLUSTERS+1; busy falls at that same edge.
- Defaults: the 8th capture is at t0+16, done is high after edge t0+17, total latency 17 clocks.
- A start coincident with done/FINISH is lost. The next start is accepted from the first cycle back in IDLE.
- reset_n assertion mid-run aborts immediately to reset values, with no done pulse.

## Configuration
- CLUSTER_EXTRACT_EARLY_DONE_EN defined: the first capture with enc_vpf=0 fills that slot and all higher slots with {0, 0, 8'hFF} on the same edge, then goes to FINISH.
  - Latency then varies: done follows edge t0+ENC_LAT*(k+1)+1, where k is the index of the empty capture.
- Not defined: always exactly MXCLUSTERS iterations. Latency is fixed as above.

## Test plan
- Reset/idle: hold reset_n=0, release with start=0 -> all outputs at reset values.
  - All 8 slots read 0xFF in adr, vpf=0, and no done.
- Two clusters: vpfs bits 5 and 100 set, cnt[5]=2, cnt[100]=0, pass_in=3'd5. Ideal encoder, ENC_LAT=2 -> done 17 clocks after start.
  - slot0={1,2,5}, slot1={1,0,100}, slots2-7 {0,0,FF}.
  - nclusters=2, pass_out=5.
- Edge clip: bit 190 set with cnt=3 -> after capture enc_vpfs[191:190]=0 and bits below 190 are untouched.
  - slot0 adr=190.
- Overflow: ten separated pads set (0,10,...,90) -> slots hold pads 0..70 and nclusters=8.
  - Pads 80 and 90 remain set in enc_vpfs at done.
- Busy start: second start 4 clocks after the first -> start_lost pulses once.
  - The first event's results are unchanged; one done only.
- Reset mid-run: reset_n low at t0+7 -> immediate reset values, no done.
  - A new start after release completes normally.
  - With CLUSTER_EXTRACT_EARLY_DONE_EN and an all-zero vpfs_in, done follows edge t0+3.

Source files
------------

// File: rtl/cluster_extract_seq.sv
// Purpose: extract up to MXCLUSTERS clusters per event by iterating one shared priority encoder over a masked pad pattern.
// Latency: slot i is captured ENC_LAT*(i+1) clocks after start; done pulses after ENC_LAT*MXCLUSTERS+1 clocks.
// Backpressure: none; a start that arrives while busy is dropped and flagged on start_lost.
// Optional feature macro: CLUSTER_EXTRACT_EARLY_DONE_EN (finish at the first empty encoder result).
module cluster_extract_seq #(
  parameter int MXKEYS     = 192,
  parameter int MXKEYBITS  = 8,
  parameter int MXCLUSTERS = 8,
  parameter int ENC_LAT    = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MXKEYS-1:0]              vpfs_in,
  input  logic [3*MXKEYS-1:0]            cnts_in,
  input  logic [2:0]                     pass_in,
  output logic [MXKEYS-1:0]              enc_vpfs,
  output logic [3*MXKEYS-1:0]            enc_cnts,
  input  logic                           enc_vpf,
  input  logic [2:0]                     enc_cnt,
  input  logic [MXKEYBITS-1:0]           enc_adr,
  output logic                           busy,
  output logic                           done,
  output logic [(4+MXKEYBITS)*MXCLUSTERS-1:0] clusters,
  output logic [3:0]                     nclusters,
  output logic [2:0]                     pass_out,
  output logic                           start_lost
);

  localparam int SLOTW = 4 + MXKEYBITS;
  localparam int WAITW = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;
  localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(ENC_LAT - 1);
  localparam logic [3:0]       ITER_LAST = 4'(MXCLUSTERS - 1);
  localparam logic [SLOTW-1:0] EMPTY_SLOT = {1'b0, 3'b000, {MXKEYBITS{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state;
  logic [3:0]         iter;
  logic [WAITW-1:0]   wait_cnt;
  logic [SLOTW-1:0]   slot_q [MXCLUSTERS];

  logic [MXKEYS-1:0]  hit_mask;
  logic [SLOTW-1:0]   cap_slot;
  logic [3:0]         nvalid;
  logic [SLOTW*MXCLUSTERS-1:0] slot_pack;

  // Pads covered by the current winner: adr..adr+cnt, clipped at the top pad; nothing for an empty or out-of-range result.
  always_comb begin
    hit_mask = '0;
    for (int k = 0; k < MXKEYS; k++) begin
      if (enc_vpf && (int'(enc_adr) < MXKEYS) &&
          (k >= int'(enc_adr)) && (k <= int'(enc_adr) + int'(enc_cnt))) begin
        hit_mask[k] = 1'b1;
      end
    end
  end

  // Slot word for the current encoder result; an empty result is stored as the idle pattern.
  always_comb begin
    cap_slot = EMPTY_SLOT;
    if (enc_vpf) begin
      cap_slot = {1'b1, enc_cnt, enc_adr};
    end
  end

  // Count valid slots and pack the working slots for publication at FINISH.
  always_comb begin
    nvalid    = '0;
    slot_pack = '0;
    for (int s = 0; s < MXCLUSTERS; s++) begin
      nvalid = nvalid + {3'b000, slot_q[s][SLOTW-1]};
      slot_pack[s*SLOTW +: SLOTW] = slot_q[s];
    end
  end

  // Sequencer FSM: load the event, run one encoder pass per slot, then publish results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      iter       <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_lost <= 1'b0;
      nclusters  <= '0;
      pass_out   <= '0;
      enc_vpfs   <= '0;
      enc_cnts   <= '0;
      clusters   <= {MXCLUSTERS{EMPTY_SLOT}};
      for (int s = 0; s < MXCLUSTERS; s++) begin
        slot_q[s] <= EMPTY_SLOT;
      end
    end else begin
      done       <= 1'b0;
      start_lost <= start && busy;
      case (state)
        IDLE: begin
          if (start) begin
            enc_vpfs <= vpfs_in;
            enc_cnts <= cnts_in;
            pass_out <= pass_in;
            iter     <= '0;
            wait_cnt <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            enc_vpfs <= enc_vpfs & ~hit_mask;
            iter     <= iter + 4'd1;
`ifdef CLUSTER_EXTRACT_EARLY_DONE_EN
            // An empty result means the pattern is exhausted: blank this and every later slot.
            for (int s = 0; s < MXCLUSTERS; s++) begin
              if ((s == int'(iter)) || (!enc_vpf && (s > int'(iter)))) begin
                slot_q[s] <= cap_slot;
              end
            end
            if (!enc_vpf || (iter == ITER_LAST)) begin
              state <= FINISH;
            end
`else
            for (int s = 0; s < MXCLUSTERS; s++) begin
              if (s == int'(iter)) begin
                slot_q[s] <= cap_slot;
              end
            end
            if (iter == ITER_LAST) begin
              state <= FINISH;
            end
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FINISH: begin
          clusters  <= slot_pack;
          nclusters <= nvalid;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_extract_seq.sv
// Purpose: directed self-checking bench for cluster_extract_seq with an ideal lowest-index priority encoder.
// Latency: encoder model registers once, so results are valid two clocks after enc_vpfs changes.
// Backpressure: exercises start-while-busy drop and mid-run reset abort.
module tb_cluster_extract_seq;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [191:0]  vpfs_in;
  logic [575:0]  cnts_in;
  logic [2:0]    pass_in;
  logic [191:0]  enc_vpfs;
  logic [575:0]  enc_cnts;
  logic          enc_vpf;
  logic [2:0]    enc_cnt;
  logic [7:0]    enc_adr;
  logic          busy;
  logic          done;
  logic [95:0]   clusters;
  logic [3:0]    nclusters;
  logic [2:0]    pass_out;
  logic          start_lost;

`ifdef CLUSTER_EXTRACT_EARLY_DONE_EN
  localparam int LAT_TWO  = 7;
  localparam int LAT_ZERO = 3;
`else
  localparam int LAT_TWO  = 17;
  localparam int LAT_ZERO = 17;
`endif
  localparam int LAT_FULL = 17;

  int errors = 0;
  int checks = 0;

  logic [191:0] v;
  logic [575:0] c;
  logic [11:0]  exp_slot [8];
  int lat, nlost, ndone, nd;

  cluster_extract_seq dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .vpfs_in(vpfs_in), .cnts_in(cnts_in), .pass_in(pass_in),
    .enc_vpfs(enc_vpfs), .enc_cnts(enc_cnts),
    .enc_vpf(enc_vpf), .enc_cnt(enc_cnt), .enc_adr(enc_adr),
    .busy(busy), .done(done), .clusters(clusters), .nclusters(nclusters),
    .pass_out(pass_out), .start_lost(start_lost)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] ideal_enc(input logic [191:0] pv, input logic [575:0] pc);
    logic [11:0] r;
    r = 12'h0FF;
    for (int k = 191; k >= 0; k--) begin
      if (pv[k]) r = {1'b1, pc[3*k +: 3], 8'(k)};
    end
    return r;
  endfunction

  initial begin
    enc_vpf = 1'b0;
    enc_cnt = 3'd0;
    enc_adr = 8'hFF;
  end

  always @(posedge clock) begin
    {enc_vpf, enc_cnt, enc_adr} <= ideal_enc(enc_vpfs, enc_cnts);
  end

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slots(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_slot%0d", tag, i), {564'd0, clusters[12*i +: 12]}, {564'd0, exp_slot[i]});
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 8; i++) exp_slot[i] = 12'h0FF;
  endtask

  // Issue one event; optionally a second start at loop index extra_at; report done latency and pulse counts.
  task automatic run(input logic [191:0] pv, input logic [575:0] pc, input logic [2:0] pp,
                     input int extra_at, output int olat, output int olost, output int odone);
    @(negedge clock);
    vpfs_in = pv;
    cnts_in = pc;
    pass_in = pp;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    olat  = -1;
    olost = 0;
    odone = 0;
    for (int k = 0; k < 60; k++) begin
      if (k == extra_at) begin
        start   = 1'b1;
        vpfs_in = '1;
        pass_in = 3'd7;
      end else begin
        start = 1'b0;
      end
      if (start_lost) olost++;
      if (done) begin
        odone++;
        if (olat < 0) olat = k;
      end
      if ((olat >= 0) && (k >= olat + 2)) break;
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    vpfs_in = '0;
    cnts_in = '0;
    pass_in = '0;

    // Reset and idle
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    nd = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("rst_busy", {575'd0, busy}, 576'd0);
    chk("rst_done_cnt", nd, 0);
    chk("rst_start_lost", {575'd0, start_lost}, 576'd0);
    chk("rst_nclusters", {572'd0, nclusters}, 576'd0);
    chk("rst_pass_out", {573'd0, pass_out}, 576'd0);
    chk("rst_enc_vpfs", {384'd0, enc_vpfs}, 576'd0);
    chk("rst_enc_cnts", enc_cnts, 576'd0);
    clear_exp();
    chk_slots("rst");

    // Two clusters
    v = '0; v[5] = 1'b1; v[100] = 1'b1;
    c = '0; c[17:15] = 3'd2;
    run(v, c, 3'd5, -1, lat, nlost, ndone);
    chk("two_lat", lat, LAT_TWO);
    chk("two_ndone", ndone, 1);
    chk("two_nlost", nlost, 0);
    clear_exp(); exp_slot[0] = 12'hA05; exp_slot[1] = 12'h864;
    chk_slots("two");
    chk("two_nclusters", {572'd0, nclusters}, 576'd2);
    chk("two_pass_out", {573'd0, pass_out}, 576'd5);
    chk("two_enc_vpfs", {384'd0, enc_vpfs}, 576'd0);
    chk("two_enc_cnts", enc_cnts, c);
    chk("two_busy_after", {575'd0, busy}, 576'd0);

    // Edge clip at the top pads
    v = '0; v[0] = 1'b1; v[190] = 1'b1; v[191] = 1'b1;
    c = '0; c[3*190 +: 3] = 3'd3; c[3*191 +: 3] = 3'd5;
    run(v, c, 3'd1, -1, lat, nlost, ndone);
    chk("clip_lat", lat, LAT_TWO);
    clear_exp(); exp_slot[0] = 12'h800; exp_slot[1] = 12'hBBE;
    chk_slots("clip");
    chk("clip_nclusters", {572'd0, nclusters}, 576'd2);
    chk("clip_top_bits", {574'd0, enc_vpfs[191:190]}, 576'd0);
    chk("clip_enc_vpfs", {384'd0, enc_vpfs}, 576'd0);

    // Overflow: ten pads, only eight slots
    v = '0;
    for (int i = 0; i < 10; i++) v[10*i] = 1'b1;
    c = '0; c[2:0] = 3'd7;
    run(v, c, 3'd3, -1, lat, nlost, ndone);
    chk("ovf_lat", lat, LAT_FULL);
    exp_slot[0] = 12'hF00;
    for (int i = 1; i < 8; i++) exp_slot[i] = 12'h800 | 12'(10*i);
    chk_slots("ovf");
    chk("ovf_nclusters", {572'd0, nclusters}, 576'd8);
    v = '0; v[80] = 1'b1; v[90] = 1'b1;
    chk("ovf_enc_vpfs", {384'd0, enc_vpfs}, {384'd0, v});

    // Start while busy
    v = '0; v[5] = 1'b1; v[100] = 1'b1;
    c = '0; c[17:15] = 3'd2;
    run(v, c, 3'd2, 3, lat, nlost, ndone);
    chk("busy_lat", lat, LAT_TWO);
    chk("busy_nlost", nlost, 1);
    chk("busy_ndone", ndone, 1);
    clear_exp(); exp_slot[0] = 12'hA05; exp_slot[1] = 12'h864;
    chk_slots("busy");
    chk("busy_pass_out", {573'd0, pass_out}, 576'd2);
    chk("busy_nclusters", {572'd0, nclusters}, 576'd2);

    // Reset in the middle of a run
    @(negedge clock);
    vpfs_in = v; cnts_in = c; pass_in = 3'd6; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    chk("mid_busy_before", {575'd0, busy}, 576'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_busy", {575'd0, busy}, 576'd0);
    chk("mid_pass_out", {573'd0, pass_out}, 576'd0);
    chk("mid_nclusters", {572'd0, nclusters}, 576'd0);
    chk("mid_enc_vpfs", {384'd0, enc_vpfs}, 576'd0);
    chk("mid_enc_cnts", enc_cnts, 576'd0);
    clear_exp();
    chk_slots("mid");
    nd = 0;
    repeat (2) begin
      @(negedge clock);
      if (done) nd++;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("mid_no_done", nd, 0);
    run(v, c, 3'd4, -1, lat, nlost, ndone);
    chk("mid_new_lat", lat, LAT_TWO);
    clear_exp(); exp_slot[0] = 12'hA05; exp_slot[1] = 12'h864;
    chk_slots("mid_new");
    chk("mid_new_pass", {573'd0, pass_out}, 576'd4);

    // Empty event
    run(192'd0, 576'd0, 3'd6, -1, lat, nlost, ndone);
    chk("zero_lat", lat, LAT_ZERO);
    chk("zero_ndone", ndone, 1);
    clear_exp();
    chk_slots("zero");
    chk("zero_nclusters", {572'd0, nclusters}, 576'd0);
    chk("zero_pass_out", {573'd0, pass_out}, 576'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
